// File: rtl/pht_update_sched.sv
// rtl/pht_update_sched.sv - single-port gshare PHT access scheduler (lookup, queued RMW update, init sweep)
module pht_update_sched #(
  parameter int SR_SIZE = 3,
  parameter int Q_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush_req,
  output logic               init_busy,
  input  logic               lu_valid,
  input  logic [SR_SIZE-1:0] lu_idx,
  output logic               lu_grant,
  output logic               lu_rsp_valid,
  output logic               lu_taken,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [SR_SIZE-1:0] upd_idx,
  input  logic               upd_taken,
  output logic               pht_en,
  output logic               pht_we,
  output logic [SR_SIZE-1:0] pht_addr,
  output logic [1:0]         pht_wdata,
  input  logic [1:0]         pht_rdata
);

  localparam int QW = $clog2(Q_DEPTH);
  localparam logic [QW:0] Q_FULL = (QW+1)'(Q_DEPTH);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_UPD_RD, S_UPD_WR} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SR_SIZE-1:0] r_sweep_ptr;
  logic [SR_SIZE-1:0] r_q_idx [Q_DEPTH];
  logic [Q_DEPTH-1:0] r_q_taken;
  logic [QW-1:0]      r_wr_ptr;
  logic [QW-1:0]      r_rd_ptr;
  logic [QW:0]        r_count;
  logic [SR_SIZE-1:0] r_hold_idx;
  logic               r_hold_taken;
  logic [1:0]         r_next_cnt;
  logic               r_lu_rsp_valid;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [1:0]         w_sat;

  assign w_full       = (r_count == Q_FULL);
  assign w_empty      = (r_count == '0);
  assign upd_ready    = !w_full && (r_state != S_INIT);
  assign w_push       = upd_valid && upd_ready;
  assign init_busy    = (r_state == S_INIT);
  assign lu_rsp_valid = r_lu_rsp_valid;
  assign lu_taken     = pht_rdata[1];

  // 2-bit saturating counter step applied to the value read back in UPD_RD
  always_comb begin
    w_sat = pht_rdata;
    if (r_hold_taken) begin
      if (pht_rdata != 2'b11) w_sat = pht_rdata + 2'b01;
    end else begin
      if (pht_rdata != 2'b00) w_sat = pht_rdata - 2'b01;
    end
  end

  // Next-state and port decode; a full queue outranks lookups so updates cannot starve forever
  always_comb begin
    w_state_nxt = r_state;
    lu_grant    = 1'b0;
    w_pop       = 1'b0;
    pht_en      = 1'b0;
    pht_we      = 1'b0;
    pht_addr    = '0;
    pht_wdata   = 2'b00;
    case (r_state)
      S_INIT: begin
        pht_en    = 1'b1;
        pht_we    = 1'b1;
        pht_addr  = r_sweep_ptr;
        pht_wdata = 2'b01;
        if (&r_sweep_ptr) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (w_full) begin
          w_pop       = 1'b1;
          pht_en      = 1'b1;
          pht_addr    = r_q_idx[r_rd_ptr];
          w_state_nxt = S_UPD_RD;
        end else if (lu_valid) begin
          lu_grant = 1'b1;
          pht_en   = 1'b1;
          pht_addr = lu_idx;
        end else if (!w_empty) begin
          w_pop       = 1'b1;
          pht_en      = 1'b1;
          pht_addr    = r_q_idx[r_rd_ptr];
          w_state_nxt = S_UPD_RD;
        end
      end
      S_UPD_RD: begin
        w_state_nxt = S_UPD_WR;
      end
      S_UPD_WR: begin
        // a flush in this cycle abandons the pending write
        pht_en      = !flush_req;
        pht_we      = !flush_req;
        pht_addr    = r_hold_idx;
        pht_wdata   = r_next_cnt;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_INIT;
    endcase
    if (flush_req) w_state_nxt = S_INIT;
  end

  // State register and init sweep pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_INIT;
      r_sweep_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (flush_req)              r_sweep_ptr <= '0;
      else if (r_state == S_INIT) r_sweep_ptr <= r_sweep_ptr + 1'b1;
    end
  end

  // Update queue pointers and occupancy; flush discards everything queued
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_req) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{QW{1'b0}}, w_push} - {{QW{1'b0}}, w_pop};
    end
  end

  // Update queue storage; contents are meaningless outside the valid window
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_idx[r_wr_ptr]   <= upd_idx;
      r_q_taken[r_wr_ptr] <= upd_taken;
    end
  end

  // Holding registers for the in-flight read-modify-write and the lookup response flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_idx     <= '0;
      r_hold_taken   <= 1'b0;
      r_next_cnt     <= 2'b00;
      r_lu_rsp_valid <= 1'b0;
    end else begin
      r_lu_rsp_valid <= lu_grant;
      if (w_pop) begin
        r_hold_idx   <= r_q_idx[r_rd_ptr];
        r_hold_taken <= r_q_taken[r_rd_ptr];
      end
      if (r_state == S_UPD_RD) r_next_cnt <= w_sat;
    end
  end

endmodule

// File: tb/tb_pht_update_sched.sv
// tb/tb_pht_update_sched.sv - directed self-checking bench for pht_update_sched
module tb_pht_update_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       flush_req;
  logic       init_busy;
  logic       lu_valid;
  logic [2:0] lu_idx;
  logic       lu_grant;
  logic       lu_rsp_valid;
  logic       lu_taken;
  logic       upd_valid;
  logic       upd_ready;
  logic [2:0] upd_idx;
  logic       upd_taken;
  logic       pht_en;
  logic       pht_we;
  logic [2:0] pht_addr;
  logic [1:0] pht_wdata;
  logic [1:0] pht_rdata = 2'b00;

  logic [1:0] mem [8];

  int checks = 0;
  int errors = 0;

  pht_update_sched #(.SR_SIZE(3), .Q_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .flush_req(flush_req), .init_busy(init_busy),
    .lu_valid(lu_valid), .lu_idx(lu_idx), .lu_grant(lu_grant),
    .lu_rsp_valid(lu_rsp_valid), .lu_taken(lu_taken),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .pht_en(pht_en), .pht_we(pht_we), .pht_addr(pht_addr), .pht_wdata(pht_wdata),
    .pht_rdata(pht_rdata)
  );

  always #5 clk = ~clk;

  // single-port SRAM model with one-cycle read latency
  always @(posedge clk) begin
    if (pht_en) begin
      if (pht_we) mem[pht_addr] <= pht_wdata;
      else        pht_rdata <= mem[pht_addr];
    end
  end

  task step();
    @(posedge clk);
    #1;
  endtask

  task settle();
    #2;
  endtask

  task wait_write(output bit found);
    found = 1'b0;
    for (int n = 0; n < 8 && !found; n++) begin
      settle();
      if (pht_en === 1'b1 && pht_we === 1'b1) found = 1'b1;
      else step();
    end
  endtask

  task test_reset();
    reset_n = 1'b0; flush_req = 1'b0; lu_valid = 1'b0; lu_idx = 3'd0;
    upd_valid = 1'b0; upd_idx = 3'd0; upd_taken = 1'b0;
    repeat (3) step();
    settle();
    checks++;
    if ({init_busy, upd_ready, lu_rsp_valid, lu_grant} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags: got %b exp 1000", {init_busy, upd_ready, lu_rsp_valid, lu_grant});
    end
    checks++;
    if ({pht_en, pht_we, pht_addr, pht_wdata} !== {2'b11, 3'd0, 2'b01}) begin
      errors++; $display("FAIL reset_port: got %b exp 11_000_01", {pht_en, pht_we, pht_addr, pht_wdata});
    end
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      checks++;
      if ({pht_en, pht_we, pht_addr, pht_wdata, init_busy, upd_ready} !== {2'b11, 3'(i), 2'b01, 2'b10}) begin
        errors++; $display("FAIL t1_sweep%0d: got %b exp %b", i,
          {pht_en, pht_we, pht_addr, pht_wdata, init_busy, upd_ready}, {2'b11, 3'(i), 2'b01, 2'b10});
      end
      step();
    end
    settle();
    checks++;
    if ({init_busy, upd_ready, pht_en} !== 3'b010) begin
      errors++; $display("FAIL t1_done: got %b exp 010", {init_busy, upd_ready, pht_en});
    end
  endtask

  task test_lookup();
    lu_valid = 1'b1; lu_idx = 3'd5;
    settle();
    checks++;
    if ({lu_grant, pht_en, pht_we, pht_addr} !== {3'b110, 3'd5}) begin
      errors++; $display("FAIL t2_grant: got %b exp 110101", {lu_grant, pht_en, pht_we, pht_addr});
    end
    step();
    lu_valid = 1'b0;
    settle();
    checks++;
    if ({lu_rsp_valid, lu_taken} !== 2'b10) begin
      errors++; $display("FAIL t2_rsp: got %b exp 10", {lu_rsp_valid, lu_taken});
    end
    step();
  endtask

  task test_counter_update();
    logic [2:0] t_idx [5];
    logic       t_tkn [5];
    logic [1:0] t_exp [5];
    t_idx = '{3'd5, 3'd5, 3'd5, 3'd2, 3'd2};
    t_tkn = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    t_exp = '{2'b10, 2'b11, 2'b11, 2'b00, 2'b00};
    for (int k = 0; k < 5; k++) begin
      upd_valid = 1'b1; upd_idx = t_idx[k]; upd_taken = t_tkn[k];
      settle();
      checks++;
      if (upd_ready !== 1'b1) begin
        errors++; $display("FAIL upd%0d_ready: got %b exp 1", k, upd_ready);
      end
      step();
      upd_valid = 1'b0;
      settle();
      checks++;
      if ({pht_en, pht_we, pht_addr} !== {2'b10, t_idx[k]}) begin
        errors++; $display("FAIL upd%0d_issue: got %b exp %b", k, {pht_en, pht_we, pht_addr}, {2'b10, t_idx[k]});
      end
      step();
      settle();
      checks++;
      if (pht_en !== 1'b0) begin
        errors++; $display("FAIL upd%0d_rd_idle: got %b exp 0", k, pht_en);
      end
      step();
      settle();
      checks++;
      if ({pht_en, pht_we, pht_addr, pht_wdata} !== {2'b11, t_idx[k], t_exp[k]}) begin
        errors++; $display("FAIL upd%0d_write: got %b exp %b", k,
          {pht_en, pht_we, pht_addr, pht_wdata}, {2'b11, t_idx[k], t_exp[k]});
      end
      step();
    end
    lu_valid = 1'b1; lu_idx = 3'd5;
    step();
    lu_valid = 1'b0;
    settle();
    checks++;
    if ({lu_rsp_valid, lu_taken} !== 2'b11) begin
      errors++; $display("FAIL t3_lookup5: got %b exp 11", {lu_rsp_valid, lu_taken});
    end
    lu_valid = 1'b1; lu_idx = 3'd2;
    step();
    lu_valid = 1'b0;
    settle();
    checks++;
    if ({lu_rsp_valid, lu_taken} !== 2'b10) begin
      errors++; $display("FAIL t4_lookup2: got %b exp 10", {lu_rsp_valid, lu_taken});
    end
    step();
  endtask

  task test_starvation();
    logic [2:0] q_idx [4];
    logic       q_tkn [4];
    logic [2:0] d_idx [3];
    logic [1:0] d_dat [3];
    bit found;
    q_idx = '{3'd0, 3'd1, 3'd6, 3'd7};
    q_tkn = '{1'b1, 1'b1, 1'b0, 1'b1};
    d_idx = '{3'd6, 3'd7, 3'd0};
    d_dat = '{2'b00, 2'b10, 2'b11};
    lu_valid = 1'b1; lu_idx = 3'd3;
    for (int k = 0; k < 4; k++) begin
      upd_valid = 1'b1; upd_idx = q_idx[k]; upd_taken = q_tkn[k];
      settle();
      checks++;
      if ({lu_grant, upd_ready} !== 2'b11) begin
        errors++; $display("FAIL t5_fill%0d: got %b exp 11", k, {lu_grant, upd_ready});
      end
      step();
    end
    upd_valid = 1'b0;
    settle();
    checks++;
    if ({lu_grant, upd_ready, pht_en, pht_we, pht_addr} !== {4'b0010, 3'd0}) begin
      errors++; $display("FAIL t5_forced_issue: got %b exp 0010000", {lu_grant, upd_ready, pht_en, pht_we, pht_addr});
    end
    step();
    settle();
    checks++;
    if ({lu_grant, pht_en} !== 2'b00) begin
      errors++; $display("FAIL t5_rd_cycle: got %b exp 00", {lu_grant, pht_en});
    end
    step();
    settle();
    checks++;
    if ({lu_grant, pht_en, pht_we, pht_addr, pht_wdata} !== {3'b011, 3'd0, 2'b10}) begin
      errors++; $display("FAIL t5_wr_cycle: got %b exp 01100010", {lu_grant, pht_en, pht_we, pht_addr, pht_wdata});
    end
    step();
    upd_valid = 1'b1; upd_idx = 3'd0; upd_taken = 1'b1;
    settle();
    checks++;
    if ({lu_grant, upd_ready} !== 2'b11) begin
      errors++; $display("FAIL t5_refill: got %b exp 11", {lu_grant, upd_ready});
    end
    step();
    upd_valid = 1'b0;
    settle();
    checks++;
    if ({lu_grant, upd_ready, pht_en, pht_we, pht_addr} !== {4'b0010, 3'd1}) begin
      errors++; $display("FAIL t5_second_forced: got %b exp 0010001", {lu_grant, upd_ready, pht_en, pht_we, pht_addr});
    end
    step();
    wait_write(found);
    checks++;
    if (!found || {pht_addr, pht_wdata} !== {3'd1, 2'b10}) begin
      errors++; $display("FAIL t5_write_b: found=%0d got %b exp 00110", found, {pht_addr, pht_wdata});
    end
    step();
    lu_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_write(found);
      checks++;
      if (!found || {pht_addr, pht_wdata} !== {d_idx[k], d_dat[k]}) begin
        errors++; $display("FAIL t5_drain%0d: found=%0d got %b exp %b", k, found, {pht_addr, pht_wdata}, {d_idx[k], d_dat[k]});
      end
      step();
    end
    settle();
    checks++;
    if (pht_en !== 1'b0) begin
      errors++; $display("FAIL t5_drained: got %b exp 0", pht_en);
    end
    step();
  endtask

  task test_flush();
    lu_valid = 1'b1; lu_idx = 3'd3;
    for (int k = 0; k < 3; k++) begin
      upd_valid = 1'b1; upd_idx = 3'(4 + k); upd_taken = 1'b1;
      step();
    end
    upd_valid = 1'b0; lu_valid = 1'b0;
    settle();
    checks++;
    if ({pht_en, pht_we, pht_addr} !== {2'b10, 3'd4}) begin
      errors++; $display("FAIL t6_issue: got %b exp 10100", {pht_en, pht_we, pht_addr});
    end
    step();
    flush_req = 1'b1;
    settle();
    checks++;
    if (pht_en !== 1'b0) begin
      errors++; $display("FAIL t6_flush_rd: got %b exp 0", pht_en);
    end
    step();
    flush_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      settle();
      checks++;
      if ({pht_en, pht_we, pht_addr, pht_wdata, init_busy, upd_ready} !== {2'b11, 3'(i), 2'b01, 2'b10}) begin
        errors++; $display("FAIL t6_sweep%0d: got %b exp %b", i,
          {pht_en, pht_we, pht_addr, pht_wdata, init_busy, upd_ready}, {2'b11, 3'(i), 2'b01, 2'b10});
      end
      step();
    end
    settle();
    checks++;
    if ({init_busy, upd_ready, pht_en} !== 3'b010) begin
      errors++; $display("FAIL t6_fifo_empty: got %b exp 010", {init_busy, upd_ready, pht_en});
    end
    lu_valid = 1'b1; lu_idx = 3'd5; flush_req = 1'b1;
    settle();
    checks++;
    if (lu_grant !== 1'b1) begin
      errors++; $display("FAIL t6_flush_lookup_grant: got %b exp 1", lu_grant);
    end
    step();
    lu_valid = 1'b0; flush_req = 1'b0;
    settle();
    checks++;
    if ({lu_rsp_valid, lu_taken, init_busy, pht_addr} !== {3'b101, 3'd0}) begin
      errors++; $display("FAIL t6_flush_lookup_rsp: got %b exp 101000", {lu_rsp_valid, lu_taken, init_busy, pht_addr});
    end
    repeat (4) step();
    settle();
    checks++;
    if ({init_busy, pht_addr} !== {1'b1, 3'd4}) begin
      errors++; $display("FAIL t6_mid_sweep: got %b exp 1100", {init_busy, pht_addr});
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({pht_addr, init_busy, lu_rsp_valid} !== {3'd0, 2'b10}) begin
      errors++; $display("FAIL t6_async_reset: got %b exp 00010", {pht_addr, init_busy, lu_rsp_valid});
    end
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      checks++;
      if ({pht_en, pht_we, pht_addr, pht_wdata, init_busy} !== {2'b11, 3'(i), 2'b01, 1'b1}) begin
        errors++; $display("FAIL t6_resweep%0d: got %b exp %b", i,
          {pht_en, pht_we, pht_addr, pht_wdata, init_busy}, {2'b11, 3'(i), 2'b01, 1'b1});
      end
      step();
    end
    settle();
    checks++;
    if ({init_busy, upd_ready} !== 2'b01) begin
      errors++; $display("FAIL t6_resweep_done: got %b exp 01", {init_busy, upd_ready});
    end
  endtask

  initial begin
    test_reset();
    test_lookup();
    test_counter_update();
    test_starvation();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
